demux_router: RTL
=================

// Module: demux_router
// PURPOSE
//   1:4 registered demultiplexer; the distribution-side counterpart of the 4:1 datapath mux.
//   Accepts one 64-bit word plus a 2-bit select per handshake.
//   Steers each word into a per-output 2-entry slot FIFO.
//   Sits between a single producer and four independent consumers; each output has its own valid/ready.
// PARAMETERS
//   DATA_W   64  width of each data word
//   NUM_OUT   4  number of output channels (fixed; SEL_W = 2)
//   DEPTH     2  entries per output slot FIFO (2 = full throughput per channel)
// PORTS
//   clk        in   1          single clock, all state on rising edge
//   rst_n      in   1          synchronous, active-low reset
//   in_valid   in   1          input word present
//   in_ready   out  1          input word accepted this cycle when in_valid && in_ready
//   in_sel     in   2          destination channel 0..3 (0=out0 ... 3=out3)
//   in_data    in   DATA_W     input word
//   out_valid  out  NUM_OUT    per-channel head valid
//   out_ready  in   NUM_OUT    per-channel consumer ready
//   out_data   out  NUM_OUT*DATA_W  flattened; channel k at [k*DATA_W +: DATA_W]
//   out_count  out  NUM_OUT*16 (DEMUX_STATS_EN only) per-channel delivered-word counters
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): all slots emptied, out_valid=0, out_data=0, out_count=0.
//     in_ready=0 while rst_n=0.
//     Reset mid-transfer discards all buffered words; no partial state survives.
//   - in_ready = rst_n && !full[in_sel]; combinational from in_sel and slot occupancy only.
//     Never depends on in_valid or out_ready (no combinational ready->ready path).
//   - Push: in_valid && in_ready at edge k -> word written into slot[in_sel].
//     Visible on out_valid[in_sel]/out_data no earlier than cycle k+1 (latency 1).
//   - Pop: out_valid[c] && out_ready[c] at an edge -> head of slot c removed.
//     Next entry (if any) is presented in the following cycle.
//   - Slot state machine per channel: EMPTY -> ONE (push), ONE -> FULL (push, no pop),
//     ONE -> EMPTY (pop, no push), ONE -> ONE (push+pop), FULL -> ONE (pop).
//     FULL with push is impossible because in_ready=0.
//   - Simultaneous push and pop on the same channel in ONE: both occur, order preserved.
//     Simultaneous pop on FULL and push attempt: push refused this cycle (in_ready computed pre-pop).
//   - Per-channel FIFO order; no ordering between channels; channels never block each other.
//   - out_data of an empty channel holds last value (don't-care); consumers qualify with out_valid.
//   - in_sel outside 0..3 impossible (2 bits); NUM_OUT fixed at 4.
// CONFIGURATION
//   DEMUX_STATS_EN defined: out_count port present.
//     Each 16-bit counter increments on every pop of its channel.
//     Wraps 16'hFFFF -> 0; cleared by reset.
//   DEMUX_STATS_EN undefined: out_count port and counters absent; datapath identical.
// STRUCTURE
//   demux_pkg: NUM_OUT, SEL_W, DATA_W default, slot_state_e {EMPTY, ONE, FULL}, CNT_W=16.
//   Sub-module demux_slot_fifo (DATA_W, DEPTH): push/pop/full/valid/head.
//     Instantiated NUM_OUT times via generate.
//   Top owns select decode, in_ready mux, optional counters.
// TESTING
//   1 reset: rst_n=0 2 cycles -> out_valid=4'b0000, in_ready=0; release -> in_ready=1.
//   2 routing: push 64'd11 sel0, 64'd22 sel1, 64'd33 sel2, 64'd44 sel3, out_ready=4'hF.
//     -> each appears on its channel exactly 1 cycle after acceptance, others stay invalid.
//   3 backpressure: out_ready[2]=0, push 3 words sel2 (5,6,7).
//     -> first two accepted, in_ready=0 on third; raise out_ready[2] -> 5,6,7 delivered in order.
//   4 independence: channel 2 FULL, push 64'd99 sel1 -> accepted same cycle, delivered next cycle.
//   5 push+pop: channel 0 in ONE with out_ready[0]=1, continuous pushes sel0 1..10.
//     -> 1 word/cycle sustained, sequence 1..10 unchanged.
//   6 reset mid-op: channels 0..3 holding data, rst_n=0 one cycle -> all out_valid=0.
//     DEMUX_STATS_EN: after 70000 pops on ch3, out_count[ch3]=70000 mod 65536=4464.

Source files
------------

// File: rtl/demux_router_pkg.sv
`default_nettype none
// ============================================================================
// demux_pkg : shared constants and slot state type for the 1:4 demux router
// Rev 1.0
// ============================================================================
package demux_pkg;

    localparam int NUM_OUT        = 4;
    localparam int SEL_W          = 2;
    localparam int DATA_W_DEFAULT = 64;
    localparam int CNT_W          = 16;

    // ONE stands for "partially occupied" when DEPTH is larger than 2
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/demux_router_if.sv
`default_nettype none
// ============================================================================
// demux_router_if : producer-side handshake plus four consumer-side channels
// Optional out_count bundle present when DEMUX_STATS_EN is defined. Rev 1.0
// ============================================================================
interface demux_router_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [DATA_W-1:0]         in_data;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT*DATA_W-1:0] out_data;

`ifdef DEMUX_STATS_EN
    logic [NUM_OUT*CNT_W-1:0]  out_count;

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
`else
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif

endinterface
`default_nettype wire

// File: rtl/demux_router_slot_fifo.sv
`default_nettype none
// ============================================================================
// demux_slot_fifo : per-channel slot FIFO with registered head/valid/full
// Rev 1.0
// ============================================================================
module demux_slot_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_push,
    input  wire logic              i_pop,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_full,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    slot_state_e        r_state;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic [DATA_W-1:0]  r_head;
    logic               r_valid;
    logic               r_full;

    logic               w_push;
    logic               w_pop;
    logic [OCC_W-1:0]   w_occ_next;
    logic [PTR_W-1:0]   w_rd_next;
    logic [PTR_W-1:0]   w_wr_next;
    logic [DATA_W-1:0]  w_head_next;

    assign w_push     = i_push && (r_state != FULL);
    assign w_pop      = i_pop  && (r_state != EMPTY);
    assign w_occ_next = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    assign w_rd_next  = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_next  = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

    // Head is kept in its own register so out_data is a clean flop output
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_occ > OCC_W'(1)) begin
                w_head_next = r_mem[w_rd_next];
            end else if (w_push) begin
                w_head_next = i_data;
            end
        end else if ((r_state == EMPTY) && w_push) begin
            w_head_next = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            r_occ  <= w_occ_next;
            r_head <= w_head_next;
            if (w_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            unique case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= ONE;
                        r_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop && (w_occ_next == OCC_W'(DEPTH))) begin
                        r_state <= FULL;
                        r_full  <= 1'b1;
                    end else if (w_pop && !w_push && (w_occ_next == '0)) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state <= ONE;
                        r_full  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_full  <= 1'b0;
                end
            endcase
        end
    end

    assign o_full  = r_full;
    assign o_valid = r_valid;
    assign o_head  = r_head;

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
// demux_router : 1:4 registered demultiplexer with per-channel slot FIFOs
// DEMUX_STATS_EN adds 16-bit per-channel delivered-word counters. Rev 1.0
// ============================================================================
module demux_router
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    demux_router_if.slave  bus
);

    logic [NUM_OUT-1:0] w_full;
    logic [NUM_OUT-1:0] w_valid;
    logic [NUM_OUT-1:0] w_push;
    logic [NUM_OUT-1:0] w_pop;
    logic [DATA_W-1:0]  w_head [NUM_OUT];
    logic               w_in_ready;

    // Ready looks only at registered occupancy, so no ready-to-ready path exists
    assign w_in_ready   = rst_n && !w_full[bus.in_sel];
    assign bus.in_ready = w_in_ready;

    always_comb begin
        w_push = '0;
        if (bus.in_valid && w_in_ready) begin
            w_push[bus.in_sel] = 1'b1;
        end
    end

    assign w_pop         = w_valid & bus.out_ready;
    assign bus.out_valid = w_valid;

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
            demux_slot_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_push  (w_push[k]),
                .i_pop   (w_pop[k]),
                .i_data  (bus.in_data),
                .o_full  (w_full[k]),
                .o_valid (w_valid[k]),
                .o_head  (w_head[k])
            );
            assign bus.out_data[k*DATA_W +: DATA_W] = w_head[k];
        end
    endgenerate

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] r_count [NUM_OUT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                r_count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_pop[k]) begin
                    r_count[k] <= r_count[k] + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_count
            assign bus.out_count[k*CNT_W +: CNT_W] = r_count[k];
        end
    endgenerate
`endif

endmodule
`default_nettype wire
